// File: rtl/matrix_pkg.sv
// Shared types and constants for the UART matrix text protocol
// (parser and printer use the same packing and dimension limits).
package matrix_pkg;

  localparam int MAX_DIM_DEF = 5;
  localparam int ELEM_W_DEF  = 8;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    GET_W,
    GET_H,
    GET_ELEM,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHAR    = 2'd1;
  localparam logic [1:0] ERR_DIM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef struct packed {
    logic       is_digit;
    logic       is_ws;
    logic [3:0] digit_val;
  } char_class_t;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier for one received byte: digit / whitespace / value.
module ascii_char_class
  import matrix_pkg::*;
(
  input  logic [7:0]  din_i,
  output char_class_t cls_o
);

  logic [7:0] off;

  // Classify the byte; digit_val is only meaningful when is_digit is set.
  always_comb begin
    off             = din_i - ASCII_ZERO;
    cls_o           = '0;
    cls_o.is_digit  = (din_i >= ASCII_ZERO) && (din_i <= 8'h39);
    cls_o.is_ws     = (din_i == ASCII_SPACE) || (din_i == ASCII_CR) || (din_i == ASCII_LF);
    cls_o.digit_val = cls_o.is_digit ? off[3:0] : 4'd0;
  end

endmodule

// File: rtl/parse_matrix.sv
// Receive-side parser for "W H e0 e1 ..." ASCII matrix text.
// Rebuilds the packed matrix (element k at data_output[k*ELEM_W +: ELEM_W]).
// Optional idle timeout: define PARSE_MATRIX_TIMEOUT_EN.
module parse_matrix
  import matrix_pkg::*;
#(
  parameter int MAX_DIM        = MAX_DIM_DEF,
  parameter int ELEM_W         = ELEM_W_DEF,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [7:0]                        din,
  input  logic                              din_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [2:0]                        width,
  output logic [2:0]                        height,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] data_output
);

  localparam int         DATA_W    = MAX_DIM * MAX_DIM * ELEM_W;
  localparam logic [3:0] MAX_DIM_V = 4'(MAX_DIM);

  state_e              state_q;
  logic                busy_q, done_q, error_q, sep_q;
  logic [1:0]          err_q;
  logic [2:0]          width_q, height_q;
  logic [4:0]          total_q, elem_cnt_q;
  logic [DATA_W-1:0]   data_q;
`ifdef PARSE_MATRIX_TIMEOUT_EN
  logic [31:0]         idle_q;
`endif

  char_class_t cls;
  logic        dim_bad;
  logic        last_elem;
  logic [4:0]  total_d;

  ascii_char_class u_cls (
    .din_i (din),
    .cls_o (cls)
  );

  // Dimension digit legality, element count and end-of-matrix detection.
  always_comb begin
    dim_bad   = (cls.digit_val == 4'd0) || (cls.digit_val > MAX_DIM_V);
    total_d   = {2'b00, width_q} * {2'b00, cls.digit_val[2:0]};
    last_elem = (elem_cnt_q == 5'(total_q - 5'd1));
  end

  // Parser FSM with registered outputs; start overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
      width_q    <= '0;
      height_q   <= '0;
      total_q    <= '0;
      elem_cnt_q <= '0;
      sep_q      <= 1'b0;
      data_q     <= '0;
`ifdef PARSE_MATRIX_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (start) begin
        // Byte arriving with start is dropped; leading whitespace is optional.
        state_q    <= GET_W;
        busy_q     <= 1'b1;
        err_q      <= ERR_NONE;
        width_q    <= '0;
        height_q   <= '0;
        total_q    <= '0;
        elem_cnt_q <= '0;
        sep_q      <= 1'b1;
        data_q     <= '0;
`ifdef PARSE_MATRIX_TIMEOUT_EN
        idle_q     <= '0;
`endif
      end else begin
        case (state_q)
          GET_W, GET_H, GET_ELEM: begin
            if (din_valid) begin
`ifdef PARSE_MATRIX_TIMEOUT_EN
              idle_q <= '0;
`endif
              if (cls.is_ws) begin
                sep_q <= 1'b1;
              end else if (!cls.is_digit || !sep_q) begin
                // Non-digit garbage or two digits without a separator.
                state_q <= ERROR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                err_q   <= ERR_CHAR;
              end else begin
                sep_q <= 1'b0;
                if (state_q != GET_ELEM && dim_bad) begin
                  state_q <= ERROR;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                  err_q   <= ERR_DIM;
                end else if (state_q == GET_W) begin
                  width_q <= cls.digit_val[2:0];
                  state_q <= GET_H;
                end else if (state_q == GET_H) begin
                  height_q <= cls.digit_val[2:0];
                  total_q  <= total_d;
                  state_q  <= GET_ELEM;
                end else begin
                  data_q[elem_cnt_q*ELEM_W +: ELEM_W] <= {{(ELEM_W-4){1'b0}}, cls.digit_val};
                  elem_cnt_q <= elem_cnt_q + 5'd1;
                  if (last_elem) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                end
              end
            end
`ifdef PARSE_MATRIX_TIMEOUT_EN
            else if (idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              err_q   <= ERR_TIMEOUT;
            end else begin
              idle_q <= idle_q + 32'd1;
            end
`else
            // No idle limit: the parser waits indefinitely for the next byte.
`endif
          end
          DONE:    state_q <= IDLE;
          ERROR:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_q;
  assign width       = width_q;
  assign height      = height_q;
  assign data_output = data_q;

endmodule
